// File: rtl/axi_rab_pkg.sv
// axi_rab_pkg: shared RAB response codes and R-channel sender state.
// Imported by axi4_rrch_err_sender.
package axi_rab_pkg;

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    PASS   = 1'b0,
    INJECT = 1'b1
  } rrch_state_e;

  function automatic logic [1:0] err_resp(input logic decerr);
    return decerr ? RESP_DECERR : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi4_rrch_drop_fifo.sv
// axi4_rrch_drop_fifo: synchronous FIFO holding dropped read transactions.
// Readiness comes from registered occupancy, so a full queue refuses a push even while popping.
module axi4_rrch_drop_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push, pop;

  always_comb begin
    in_ready  = (cnt_q != FULL);
    out_valid = (cnt_q != '0);
    out_data  = mem_q[rd_ptr_q];
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: rtl/axi4_rrch_err_sender.sv
// axi4_rrch_err_sender: forwards master R beats, injects error bursts for dropped reads.
// Optional completed-burst counter port enabled by AXI4_RRCH_DROP_CNT_EN.
module axi4_rrch_err_sender
  import axi_rab_pkg::*;
#(
  parameter int unsigned C_AXI_DATA_WIDTH  = 32,
  parameter int unsigned C_AXI_ID_WIDTH    = 4,
  parameter int unsigned C_AXI_USER_WIDTH  = 4,
  parameter int unsigned C_DROP_FIFO_DEPTH = 4
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arst,
  input  logic                        trans_drop,
  output logic                        trans_drop_ready,
  input  logic [C_AXI_ID_WIDTH-1:0]   trans_id,
  input  logic [7:0]                  trans_len,
  input  logic                        trans_decerr,
  output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_rid,
  output logic [1:0]                  s_axi4_rresp,
  output logic [C_AXI_DATA_WIDTH-1:0] s_axi4_rdata,
  output logic                        s_axi4_rlast,
  output logic [C_AXI_USER_WIDTH-1:0] s_axi4_ruser,
  output logic                        s_axi4_rvalid,
  input  logic                        s_axi4_rready,
  input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [1:0]                  m_axi4_rresp,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic                        m_axi4_rlast,
  input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_ruser,
  input  logic                        m_axi4_rvalid,
  output logic                        m_axi4_rready
`ifdef AXI4_RRCH_DROP_CNT_EN
  ,
  output logic [31:0]                 drop_cnt
`endif
);

  localparam int unsigned FW = C_AXI_ID_WIDTH + 9;

  rrch_state_e               state_q, state_d;
  logic [7:0]                beat_cnt_q, beat_cnt_d;
  logic                      mid_burst_q, mid_burst_d;
  logic [FW-1:0]             push_data, head_data;
  logic                      head_valid;
  logic [C_AXI_ID_WIDTH-1:0] head_id;
  logic [7:0]                head_len;
  logic                      head_decerr;
  logic                      fwd_acc, inj_acc, inj_last;

  assign push_data = {trans_id, trans_len, trans_decerr};
  assign {head_id, head_len, head_decerr} = head_data;

  axi4_rrch_drop_fifo #(
    .WIDTH (FW),
    .DEPTH (C_DROP_FIFO_DEPTH)
  ) u_drop_fifo (
    .clk       (axi4_aclk),
    .rst       (axi4_arst),
    .in_valid  (trans_drop),
    .in_ready  (trans_drop_ready),
    .in_data   (push_data),
    .out_valid (head_valid),
    .out_ready (inj_last),
    .out_data  (head_data)
  );

  always_comb begin
    s_axi4_rid    = m_axi4_rid;
    s_axi4_rresp  = m_axi4_rresp;
    s_axi4_rdata  = m_axi4_rdata;
    s_axi4_rlast  = m_axi4_rlast;
    s_axi4_ruser  = m_axi4_ruser;
    s_axi4_rvalid = m_axi4_rvalid;
    m_axi4_rready = s_axi4_rready;
    if (state_q == INJECT) begin
      s_axi4_rid    = head_id;
      s_axi4_rresp  = err_resp(head_decerr);
      s_axi4_rdata  = '0;
      s_axi4_rlast  = (beat_cnt_q == head_len);
      s_axi4_ruser  = '0;
      s_axi4_rvalid = 1'b1;
      m_axi4_rready = 1'b0;
    end
  end

  always_comb begin
    fwd_acc     = (state_q == PASS) && m_axi4_rvalid && s_axi4_rready;
    inj_acc     = (state_q == INJECT) && s_axi4_rready;
    inj_last    = inj_acc && (beat_cnt_q == head_len);
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    mid_burst_d = mid_burst_q;
    if (fwd_acc) begin
      mid_burst_d = !m_axi4_rlast;
    end
    unique case (state_q)
      PASS: begin
        // A burst opened in this very cycle also blocks injection.
        if (head_valid && !mid_burst_q && !(fwd_acc && !m_axi4_rlast)) begin
          state_d = INJECT;
        end
      end
      INJECT: begin
        if (inj_last) begin
          state_d    = PASS;
          beat_cnt_d = '0;
        end else if (inj_acc) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: state_d = PASS;
    endcase
  end

`ifdef AXI4_RRCH_DROP_CNT_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (inj_last && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      state_q     <= PASS;
      beat_cnt_q  <= '0;
      mid_burst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      mid_burst_q <= mid_burst_d;
    end
  end

endmodule
